// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, clocks out one
// command byte with odd parity on device-generated clock falls, then checks the device ACK.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_MAX   = IW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [1:0]    ERR_NONE    = 2'b00;
  localparam logic [1:0]    ERR_TIMEOUT = 2'b01;
  localparam logic [1:0]    ERR_NOACK   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_DATA      = 3'd2,
    S_ACK       = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_e;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_e          state_q, state_d;
  logic [1:0]      clk_sync_q, dat_sync_q;
  logic            clk_prev_q;
  logic [8:0]      shift_q, shift_d;
  logic [IW-1:0]   inh_cnt_q, inh_cnt_d;
  logic [TW-1:0]   tout_cnt_q, tout_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            clk_oe_q, clk_oe_d;
  logic            dat_oe_q, dat_oe_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [1:0]      err_code_q, err_code_d;

  logic clk_s, dat_s, fall_s, accept_s, timeout_s;

  assign clk_s     = clk_sync_q[1];
  assign dat_s     = dat_sync_q[1];
  assign fall_s    = clk_prev_q & ~clk_s;
  assign accept_s  = tx_valid & ready_q & (state_q == S_IDLE);
  assign timeout_s = (tout_cnt_q == TOUT_LAST);

  // Pad synchronisers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
      clk_prev_q <= clk_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= 9'd0;
      inh_cnt_q  <= '0;
      tout_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      inh_cnt_q  <= inh_cnt_d;
      tout_cnt_q <= tout_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state and registered-output logic; ready lags the return to IDLE by one cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    inh_cnt_d  = inh_cnt_q;
    tout_cnt_d = tout_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    busy_d     = busy_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    ready_d    = (state_q == S_IDLE) && !accept_s;

    case (state_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (accept_s) begin
          shift_d    = {odd_parity(tx_data), tx_data};
          inh_cnt_d  = '0;
          bit_cnt_d  = 4'd0;
          clk_oe_d   = 1'b1;
          busy_d     = 1'b1;
          err_code_d = ERR_NONE;
          state_d    = S_INHIBIT;
        end else begin
          busy_d = 1'b0;
        end
      end

      S_INHIBIT: begin
        clk_oe_d = 1'b1;
        dat_oe_d = 1'b0;
        if (inh_cnt_q == INH_LAST) begin
          // Request-to-send: start bit low and clock released together.
          clk_oe_d   = 1'b0;
          dat_oe_d   = 1'b1;
          tout_cnt_d = '0;
          bit_cnt_d  = 4'd0;
          state_d    = S_DATA;
        end else if (inh_cnt_q != INH_MAX) begin
          inh_cnt_d = inh_cnt_q + {{(IW-1){1'b0}}, 1'b1};
        end else begin
          inh_cnt_d = inh_cnt_q;
        end
      end

      S_DATA, S_ACK, S_WAIT_IDLE: begin
        if (timeout_s) begin
          clk_oe_d   = 1'b0;
          dat_oe_d   = 1'b0;
          busy_d     = 1'b0;
          error_d    = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = S_IDLE;
        end else begin
          if (tout_cnt_q != TOUT_MAX) begin
            tout_cnt_d = tout_cnt_q + {{(TW-1){1'b0}}, 1'b1};
          end else begin
            tout_cnt_d = tout_cnt_q;
          end
          case (state_q)
            S_DATA: begin
              if (fall_s) begin
                // Bits 0..7 are data LSB first, bit 8 is parity, bit 9 releases the stop bit.
                if (bit_cnt_q <= 4'd8) begin
                  dat_oe_d = ~shift_q[bit_cnt_q];
                end else begin
                  dat_oe_d = 1'b0;
                  state_d  = S_ACK;
                end
                if (bit_cnt_q != 4'hF) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                end else begin
                  bit_cnt_d = bit_cnt_q;
                end
              end else begin
                dat_oe_d = dat_oe_q;
              end
            end
            S_ACK: begin
              if (fall_s) begin
                if (!dat_s) begin
                  state_d = S_WAIT_IDLE;
                end else begin
                  clk_oe_d   = 1'b0;
                  dat_oe_d   = 1'b0;
                  busy_d     = 1'b0;
                  error_d    = 1'b1;
                  err_code_d = ERR_NOACK;
                  state_d    = S_IDLE;
                end
              end else begin
                state_d = S_ACK;
              end
            end
            S_WAIT_IDLE: begin
              if (clk_s && dat_s) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                state_d = S_WAIT_IDLE;
              end
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_ready   = ready_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = error_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter: a simple device model generates the PS/2 clock
// and ACK; frame bits, pulse counts, timing and error codes are checked against constants.
module tb_ps2_host_transmitter;

  localparam int INH  = 5000;
  localparam int TOUT = 2000;
  localparam int H    = 30;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic [1:0] err_code;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic inj_clk = 1'b0;
  logic ps2_clk_pad, ps2_dat_pad;

  // Wired-AND pads; inj_clk lets the bench force edges through a host-held clock.
  assign ps2_clk_pad = inj_clk ? dev_clk : (dev_clk & ~ps2_clk_oe);
  assign ps2_dat_pad = dev_dat & ~ps2_dat_oe;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk_in(ps2_clk_pad),
    .ps2_dat_in(ps2_dat_pad),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .err_code  (err_code)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_error === 1'b1) err_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] data, input bit hold);
    int i;
    tx_data  = data;
    tx_valid = 1'b1;
    i = 0;
    do begin
      tick(1);
      i++;
    end while (tx_busy !== 1'b1 && i < 100);
    check("accept_busy", {31'd0, tx_busy}, 32'd1);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic measure_inhibit(input bit inject, output int cnt);
    cnt = 0;
    while (ps2_clk_oe === 1'b1 && cnt < INH + 1000) begin
      if (inject && cnt >= 100 && cnt < 300) begin
        inj_clk = 1'b1;
        dev_clk = ((cnt / 10) % 2) == 0;
      end else begin
        inj_clk = 1'b0;
        dev_clk = 1'b1;
      end
      cnt++;
      tick(1);
    end
    inj_clk = 1'b0;
    dev_clk = 1'b1;
  endtask

  task automatic dev_frame(input int abort_at, input bit ack, output logic [10:0] bits);
    bits = 11'd0;
    tick(2);
    bits[0] = ps2_dat_pad;
    tick(H);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      tick(H);
      bits[k] = ps2_dat_pad;
      dev_clk = 1'b1;
      if (k == abort_at) return;
      tick(H);
    end
    dev_dat = ack ? 1'b0 : 1'b1;
    tick(5);
    dev_clk = 1'b0;
    tick(H);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
  endtask

  task automatic full_txn(input logic [7:0] data, input logic par, input bit inject, input string tag);
    int cnt, d0, e0;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    send(data, 1'b0);
    measure_inhibit(inject, cnt);
    check({tag, "_inhibit_len"}, cnt, INH);
    check({tag, "_start_oe"}, {31'd0, ps2_dat_oe}, 32'd1);
    dev_frame(99, 1'b1, bits);
    check({tag, "_frame"}, {21'd0, bits}, {21'd0, 1'b1, par, data, 1'b0});
    tick(10);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_err_pulses"}, err_cnt - e0, 0);
    check({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
    check({tag, "_idle"}, {28'd0, tx_ready, tx_busy, ps2_clk_oe, ps2_dat_oe}, 32'b1000);
  endtask

  initial begin
    int cnt, d0, e0, n;
    logic [10:0] bits;

    // Reset state
    tick(3);
    check("rst_outputs", {25'd0, tx_ready, tx_busy, tx_done, tx_error, err_code, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    reset = 1'b0;
    check("rst_ready_low_at_release", {31'd0, tx_ready}, 32'd0);
    tick(1);
    check("rst_ready_rises", {31'd0, tx_ready}, 32'd1);

    // 1: 0xED with ACK
    full_txn(8'hED, 1'b1, 1'b0, "t1");

    // 2: 0xF4 while tx_valid stays high with a new byte queued behind it
    d0 = done_cnt;
    send(8'hF4, 1'b1);
    tx_data = 8'h5A;
    measure_inhibit(1'b0, cnt);
    check("t2_inhibit_len", cnt, INH);
    check("t2_busy_held", {31'd0, tx_busy}, 32'd1);
    dev_frame(99, 1'b1, bits);
    check("t2_frame", {21'd0, bits}, {21'd0, 1'b1, 1'b0, 8'hF4, 1'b0});
    tick(10);
    check("t2_done_pulses", done_cnt - d0, 1);
    check("t2_second_accepted", {30'd0, tx_busy, ps2_clk_oe}, 32'b11);
    tx_valid = 1'b0;
    measure_inhibit(1'b0, cnt);
    check("t2b_inhibit_partial", {31'd0, (cnt > INH - 20) && (cnt < INH)}, 32'd1);
    dev_frame(99, 1'b1, bits);
    check("t2b_frame", {21'd0, bits}, {21'd0, 1'b1, 1'b1, 8'h5A, 1'b0});
    tick(10);
    check("t2b_done_pulses", done_cnt - d0, 2);

    // 3: no ACK on 0x00
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00, 1'b0);
    measure_inhibit(1'b0, cnt);
    dev_frame(99, 1'b0, bits);
    check("t3_frame", {21'd0, bits}, {21'd0, 1'b1, 1'b1, 8'h00, 1'b0});
    tick(10);
    check("t3_err_pulses", err_cnt - e0, 1);
    check("t3_done_pulses", done_cnt - d0, 0);
    check("t3_err_code", {30'd0, err_code}, 32'd2);
    check("t3_idle", {28'd0, tx_ready, tx_busy, ps2_clk_oe, ps2_dat_oe}, 32'b1000);

    // 4: device never clocks
    e0 = err_cnt;
    send(8'h3C, 1'b0);
    measure_inhibit(1'b0, cnt);
    check("t4_inhibit_len", cnt, INH);
    n = 0;
    while (tx_error !== 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    check("t4_timeout_len", n, TOUT);
    check("t4_err_code", {30'd0, err_code}, 32'd1);
    check("t4_lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("t4_busy_clear", {31'd0, tx_busy}, 32'd0);
    tick(1);
    check("t4_pulse_then_ready", {30'd0, tx_error, tx_ready}, 32'b01);
    check("t4_err_code_held", {30'd0, err_code}, 32'd1);
    tick(2);
    check("t4_err_pulses", err_cnt - e0, 1);

    // 5: asynchronous reset after five data bits
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00, 1'b0);
    measure_inhibit(1'b0, cnt);
    dev_frame(5, 1'b1, bits);
    check("t5_dat_low_before_reset", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'b01);
    #1 reset = 1'b1;
    #1;
    check("t5_async_release", {28'd0, ps2_clk_oe, ps2_dat_oe, tx_busy, tx_ready}, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    check("t5_ready_after_reset", {31'd0, tx_ready}, 32'd1);
    check("t5_no_pulses", {done_cnt - d0 + err_cnt - e0}, 32'd0);
    full_txn(8'hFF, 1'b1, 1'b0, "t5");

    // 6: spurious falls while idle and during inhibit
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 6; i++) begin
      dev_clk = 1'b0;
      tick(10);
      dev_clk = 1'b1;
      tick(10);
    end
    check("t6_idle_state", {28'd0, tx_ready, tx_busy, ps2_clk_oe, ps2_dat_oe}, 32'b1000);
    check("t6_idle_no_pulses", {done_cnt - d0 + err_cnt - e0}, 32'd0);
    full_txn(8'h81, 1'b1, 1'b1, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
